// File: rtl/if_else_select_pipe.sv
// Condition-driven select of if/else branch results with a buffer on each of the
// three input streams, a registered valid/ready output and taken/total statistics.

module if_else_select_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;

   // Ready depends only on the registered count, so a full buffer refuses a push
   // even when it is popped on the same edge.
   assign in_ready = (count != FULL_CNT);
   assign empty    = (count == '0);
   assign push     = in_valid & in_ready;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end
endmodule

module if_else_select_pipe #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16,
   parameter bit INVERT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] if_data,
   input  logic             if_valid,
   output logic             if_ready,
   input  logic [WIDTH-1:0] else_data,
   input  logic             else_valid,
   output logic             else_ready,
   input  logic             cond,
   input  logic             cond_valid,
   output logic             cond_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] total_cnt,
   output logic             ovf
);
   logic [WIDTH-1:0] if_head;
   logic [WIDTH-1:0] else_head;
   logic             cond_head;
   logic             if_empty;
   logic             else_empty;
   logic             cond_empty;
   logic             fire;
   logic             sel;

   function automatic logic [WIDTH-1:0] select_branch(input logic s,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
      return s ? a : b;
   endfunction

   if_else_select_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_if_fifo (
      .clk(clk), .reset(reset), .in_data(if_data), .in_valid(if_valid),
      .in_ready(if_ready), .pop(fire), .head(if_head), .empty(if_empty)
   );

   if_else_select_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_else_fifo (
      .clk(clk), .reset(reset), .in_data(else_data), .in_valid(else_valid),
      .in_ready(else_ready), .pop(fire), .head(else_head), .empty(else_empty)
   );

   if_else_select_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_cond_fifo (
      .clk(clk), .reset(reset), .in_data(cond), .in_valid(cond_valid),
      .in_ready(cond_ready), .pop(fire), .head(cond_head), .empty(cond_empty)
   );

   // Both branch heads are consumed on every fire so pairing stays in arrival order.
   assign fire = ~if_empty & ~else_empty & ~cond_empty & (~out_valid | out_ready);
   assign sel  = cond_head ^ INVERT;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (fire) begin
         out_data  <= select_branch(sel, if_head, else_head);
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         taken_cnt <= '0;
         total_cnt <= '0;
         ovf       <= 1'b0;
      end else if (fire) begin
         total_cnt <= total_cnt + CNT_W'(1);
         if (sel) taken_cnt <= taken_cnt + CNT_W'(1);
         if ((&total_cnt) || (sel && (&taken_cnt))) ovf <= 1'b1;
      end
   end
endmodule

// File: tb/tb_if_else_select_pipe.sv
// Bench for if_else_select_pipe: directed scenarios plus a randomized run against a
// queue-based pairing model, using default, inverted and narrow-counter builds.

module tb_if_else_select_pipe;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] if_data = '0, else_data = '0;
   logic        if_valid = 1'b0, else_valid = 1'b0;
   logic        cond = 1'b0, cond_valid = 1'b0;
   logic        out_ready = 1'b1;

   logic        m_if_ready, m_else_ready, m_cond_ready, m_out_valid, m_ovf;
   logic [31:0] m_out_data;
   logic [15:0] m_taken, m_total;
   logic        i_if_ready, i_else_ready, i_cond_ready, i_out_valid, i_ovf;
   logic [31:0] i_out_data;
   logic [15:0] i_taken, i_total;
   logic        s_if_ready, s_else_ready, s_cond_ready, s_out_valid, s_ovf;
   logic [31:0] s_out_data;
   logic [3:0]  s_taken, s_total;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   if_else_select_pipe u_main (
      .clk(clk), .reset(reset),
      .if_data(if_data), .if_valid(if_valid), .if_ready(m_if_ready),
      .else_data(else_data), .else_valid(else_valid), .else_ready(m_else_ready),
      .cond(cond), .cond_valid(cond_valid), .cond_ready(m_cond_ready),
      .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(out_ready),
      .taken_cnt(m_taken), .total_cnt(m_total), .ovf(m_ovf)
   );

   if_else_select_pipe #(.INVERT(1'b1)) u_inv (
      .clk(clk), .reset(reset),
      .if_data(if_data), .if_valid(if_valid), .if_ready(i_if_ready),
      .else_data(else_data), .else_valid(else_valid), .else_ready(i_else_ready),
      .cond(cond), .cond_valid(cond_valid), .cond_ready(i_cond_ready),
      .out_data(i_out_data), .out_valid(i_out_valid), .out_ready(out_ready),
      .taken_cnt(i_taken), .total_cnt(i_total), .ovf(i_ovf)
   );

   if_else_select_pipe #(.CNT_W(4)) u_small (
      .clk(clk), .reset(reset),
      .if_data(if_data), .if_valid(if_valid), .if_ready(s_if_ready),
      .else_data(else_data), .else_valid(else_valid), .else_ready(s_else_ready),
      .cond(cond), .cond_valid(cond_valid), .cond_ready(s_cond_ready),
      .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
      .taken_cnt(s_taken), .total_cnt(s_total), .ovf(s_ovf)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_triple(input logic [31:0] a, input logic [31:0] b, input logic c);
      if_data = a; else_data = b; cond = c;
      if_valid = 1'b1; else_valid = 1'b1; cond_valid = 1'b1;
   endtask

   task automatic idle_inputs();
      if_valid = 1'b0; else_valid = 1'b0; cond_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (m_out_valid !== 1'b0 || m_out_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_out: valid=%b data=%h, required 0/0", m_out_valid, m_out_data);
      end
      tests_run++;
      if (m_taken !== 16'h0 || m_total !== 16'h0 || m_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_cnt: taken=%0d total=%0d ovf=%b, required 0/0/0", m_taken, m_total, m_ovf);
      end
      tests_run++;
      if ({m_if_ready, m_else_ready, m_cond_ready} !== 3'b111) begin
         tests_failed++;
         $display("FAIL reset_ready: %b, required 111", {m_if_ready, m_else_ready, m_cond_ready});
      end
      reset = 1'b1;
   endtask

   task automatic test_latency();
      @(negedge clk);
      out_ready = 1'b1;
      drive_triple(32'h11, 32'h22, 1'b1);
      @(negedge clk);
      idle_inputs();
      tests_run++;
      if (m_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL latency_early: out_valid=%b one cycle after push, required 0", m_out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (m_out_valid !== 1'b1 || m_out_data !== 32'h11 || m_taken !== 16'd1 || m_total !== 16'd1) begin
         tests_failed++;
         $display("FAIL latency_out: valid=%b data=%h taken=%0d total=%0d, required 1/11/1/1",
                  m_out_valid, m_out_data, m_taken, m_total);
      end
      tests_run++;
      if (i_out_data !== 32'h22 || i_taken !== 16'd0 || i_total !== 16'd1) begin
         tests_failed++;
         $display("FAIL invert_cond1: data=%h taken=%0d total=%0d, required 22/0/1", i_out_data, i_taken, i_total);
      end
      @(negedge clk);
      tests_run++;
      if (m_out_valid !== 1'b0 || m_out_data !== 32'h11) begin
         tests_failed++;
         $display("FAIL drain_hold: valid=%b data=%h, required 0/11", m_out_valid, m_out_data);
      end
   endtask

   task automatic test_select();
      drive_triple(32'h11, 32'h22, 1'b0);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (m_out_valid !== 1'b1 || m_out_data !== 32'h22 || m_taken !== 16'd1 || m_total !== 16'd2) begin
         tests_failed++;
         $display("FAIL select_cond0: valid=%b data=%h taken=%0d total=%0d, required 1/22/1/2",
                  m_out_valid, m_out_data, m_taken, m_total);
      end
      tests_run++;
      if (i_out_data !== 32'h11 || i_taken !== 16'd1) begin
         tests_failed++;
         $display("FAIL invert_cond0: data=%h taken=%0d, required 11/1", i_out_data, i_taken);
      end
      @(negedge clk);
   endtask

   task automatic test_skew();
      logic [31:0] exp_q[$];
      logic [3:0]  conds;
      int          k, got;
      conds = 4'b0101;
      exp_q = '{32'hA0, 32'hB1, 32'hA2, 32'hB3};
      for (int i = 0; i < 4; i++) begin
         cond = conds[i]; cond_valid = 1'b1;
         @(negedge clk);
      end
      cond_valid = 1'b0;
      repeat (5) @(negedge clk);
      tests_run++;
      if (m_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL skew_wait: out_valid=%b with branches missing, required 0", m_out_valid);
      end
      k = 0; got = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (k < 4) begin
            if_data = 32'hA0 + k; else_data = 32'hB0 + k;
            if_valid = 1'b1; else_valid = 1'b1;
            if (m_if_ready && m_else_ready) k++;
         end else begin
            if_valid = 1'b0; else_valid = 1'b0;
         end
         if (m_out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0 || m_out_data !== exp_q[0]) begin
               tests_failed++;
               $display("FAIL skew_order: got %h, required %h", m_out_data,
                        exp_q.size() ? exp_q[0] : 32'hx);
            end
            if (exp_q.size()) void'(exp_q.pop_front());
            got++;
         end
         @(negedge clk);
      end
      idle_inputs();
      tests_run++;
      if (got != 4 || m_taken !== 16'd3 || m_total !== 16'd6) begin
         tests_failed++;
         $display("FAIL skew_count: outputs=%0d taken=%0d total=%0d, required 4/3/6", got, m_taken, m_total);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_q[$];
      logic [31:0] first;
      int          k, got;
      logic        acc;
      out_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 32'hC0 + i : 32'hD0 + i);
      first = exp_q[0];
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (k < 6) begin
            drive_triple(32'hC0 + k, 32'hD0 + k, (k % 2 == 0));
            acc = m_if_ready;
         end else begin
            idle_inputs();
            acc = 1'b0;
         end
         @(negedge clk);
         if (acc) k++;
         if (cyc >= 3) begin
            tests_run++;
            if (m_out_valid !== 1'b1 || m_out_data !== first) begin
               tests_failed++;
               $display("FAIL bp_stable: cycle %0d valid=%b data=%h, required 1/%h", cyc, m_out_valid, m_out_data, first);
            end
         end
      end
      tests_run++;
      if (k != 5 || {m_if_ready, m_else_ready, m_cond_ready} !== 3'b000) begin
         tests_failed++;
         $display("FAIL bp_full: accepted=%0d ready=%b, required 5/000", k, {m_if_ready, m_else_ready, m_cond_ready});
      end
      idle_inputs();
      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         if (m_out_valid && out_ready) begin
            tests_run++;
            if (m_out_data !== exp_q[got]) begin
               tests_failed++;
               $display("FAIL bp_order: item %0d got %h, required %h", got, m_out_data, exp_q[got]);
            end
            got++;
         end
         @(negedge clk);
         if (got >= 5) break;
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (got != 5 || m_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_release: delivered=%0d valid=%b, required 5/0", got, m_out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_triple(32'hE0 + i, 32'hF0 + i, 1'b1);
         @(negedge clk);
      end
      idle_inputs();
      #3 reset = 1'b0;
      #1;
      tests_run++;
      if (m_out_valid !== 1'b0 || m_out_data !== 32'h0 || m_taken !== 16'h0 || m_total !== 16'h0 || m_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: valid=%b data=%h taken=%0d total=%0d ovf=%b, required all 0",
                  m_out_valid, m_out_data, m_taken, m_total, m_ovf);
      end
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (m_out_valid) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         tests_failed++;
         $display("FAIL mid_stale: %0d stale outputs after reset, required 0", seen);
      end
      drive_triple(32'h55, 32'h66, 1'b1);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (m_out_valid !== 1'b1 || m_out_data !== 32'h55 || m_total !== 16'd1) begin
         tests_failed++;
         $display("FAIL mid_fresh: valid=%b data=%h total=%0d, required 1/55/1", m_out_valid, m_out_data, m_total);
      end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      int k, got, first_cyc, last_cyc;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      k = 0; got = 0; first_cyc = -1; last_cyc = -1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (k < 16) begin
            drive_triple(32'h100 + k, 32'h200 + k, 1'b1);
            if (m_if_ready) k++;
         end else begin
            idle_inputs();
         end
         if (m_out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            tests_run++;
            if (m_out_data !== 32'h100 + got) begin
               tests_failed++;
               $display("FAIL wrap_data: item %0d got %h, required %h", got, m_out_data, 32'h100 + got);
            end
            got++;
         end
         @(negedge clk);
      end
      idle_inputs();
      tests_run++;
      if (got != 16 || last_cyc - first_cyc != 15) begin
         tests_failed++;
         $display("FAIL throughput: %0d outputs over %0d cycles, required 16 over 16", got, last_cyc - first_cyc + 1);
      end
      tests_run++;
      if (s_taken !== 4'd0 || s_total !== 4'd0 || s_ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_small: taken=%0d total=%0d ovf=%b, required 0/0/1", s_taken, s_total, s_ovf);
      end
      tests_run++;
      if (m_taken !== 16'd16 || m_total !== 16'd16 || m_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_wide: taken=%0d total=%0d ovf=%b, required 16/16/0", m_taken, m_total, m_ovf);
      end
   endtask

   task automatic test_random();
      logic [31:0] qi[$];
      logic [31:0] qe[$];
      logic        qc[$];
      logic [31:0] exp_m, exp_i;
      int          n_out, n_taken, errs;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n_out = 0; n_taken = 0; errs = 0;
      for (int cyc = 0; cyc < 460; cyc++) begin
         out_ready = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (m_out_valid && out_ready) begin
            if (qc.size() == 0) begin
               errs++;
               $display("FAIL rand_extra: output %h with no pending inputs", m_out_data);
            end else begin
               exp_m = qc[0] ? qi[0] : qe[0];
               exp_i = qc[0] ? qe[0] : qi[0];
               if (qc[0]) n_taken++;
               if (m_out_data !== exp_m || i_out_data !== exp_i || i_out_valid !== 1'b1) begin
                  errs++;
                  $display("FAIL rand_data: out %0d main=%h inv=%h, required %h/%h", n_out, m_out_data, i_out_data, exp_m, exp_i);
               end
               void'(qi.pop_front()); void'(qe.pop_front()); void'(qc.pop_front());
               n_out++;
            end
         end
         if (cyc < 400) begin
            if_valid = $urandom_range(0, 1); else_valid = $urandom_range(0, 1);
            cond_valid = $urandom_range(0, 1);
            if_data = $urandom; else_data = $urandom; cond = $urandom_range(0, 1);
         end else begin
            idle_inputs();
         end
         if (if_valid && m_if_ready) qi.push_back(if_data);
         if (else_valid && m_else_ready) qe.push_back(else_data);
         if (cond_valid && m_cond_ready) qc.push_back(cond);
         @(negedge clk);
      end
      tests_run++;
      if (errs != 0) begin
         tests_failed++;
         $display("FAIL rand_stream: %0d data errors, required 0", errs);
      end
      tests_run++;
      if (m_total !== 16'(n_out) || m_taken !== 16'(n_taken) || n_out == 0) begin
         tests_failed++;
         $display("FAIL rand_counts: taken=%0d total=%0d, required %0d/%0d (nonzero)", m_taken, m_total, n_taken, n_out);
      end
      tests_run++;
      if (m_out_valid !== 1'b0 || (qi.size() > 0 && qe.size() > 0 && qc.size() > 0)) begin
         tests_failed++;
         $display("FAIL rand_drain: valid=%b pending=%0d/%0d/%0d, required drained", m_out_valid, qi.size(), qe.size(), qc.size());
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_select();
      test_skew();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
